mole_round_ctrl: RTL and testbench
==================================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 SHALL have parameter ROUND_CYCLES, default 50_000_000, giving the active-window length in clocks.
REQ-002 SHALL have parameter NUM_ROUNDS, default 10, giving the rounds per game.
REQ-003 SHALL have parameter LFSR_SEED, default 18'h2A5F3, giving the non-zero pattern LFSR reset value.
REQ-004 SHALL have parameter ROUND_STEP, default 2_500_000, giving the per-round window reduction (speedup only).
REQ-005 SHALL have parameter ROUND_MIN, default 10_000_000, giving the window floor (speedup only).
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port start, input, 1 bit: synchronous pulse that starts a game.
REQ-009 SHALL have port sw, input, 18 bits: raw asynchronous whack switches.
REQ-010 SHALL have port led, output, 18 bits: lit-mole pattern, consumed by the scorer.
REQ-011 SHALL have port whacked, output, 18 bits: hit mask, non-zero only in the report cycle.
REQ-012 SHALL have port round_done, output, 1 bit: one-cycle pulse coincident with the report cycle.
REQ-013 SHALL have port busy, output, 1 bit: high from LOAD through DONE.
REQ-014 SHALL have port game_over, output, 1 bit: one-cycle pulse in DONE.
REQ-015 SHALL have port round_idx, output, 4 bits: current round, 0-based.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, ACTIVE, REPORT, DONE.
REQ-017 SHALL go IDLE->LOAD on start=1; start SHALL be ignored in every other state.
REQ-018 SHALL, in LOAD, advance the 18-bit Fibonacci LFSR (x^18+x^11+1) once, latch its value as the pattern, clear the hit mask, load the timer with window-1, and go to ACTIVE next cycle.
REQ-019 SHALL drive led with the latched pattern in ACTIVE and REPORT, and with 0 in all other states.
REQ-020 SHALL pass sw through a 2-flop synchronizer; a hit SHALL be a synchronized 0->1 edge on bit i while in ACTIVE.
REQ-021 SHALL set hit-mask bit i on a hit only if pattern bit i is 1; a hit on an unlit bit SHALL be ignored, and repeated hits on a set bit SHALL be idempotent.
REQ-022 SHALL decrement the timer each ACTIVE cycle and leave ACTIVE for REPORT when timer==0 or when (mask | new hits)==pattern, whichever comes first.
REQ-023 SHALL record a hit arriving in the same cycle as timer expiry.
REQ-024 SHALL, in REPORT (exactly 1 cycle), drive whacked=mask and round_done=1; whacked SHALL be 0 in every other cycle.
REQ-025 SHALL go REPORT->DONE if round_idx==NUM_ROUNDS-1, otherwise increment round_idx and go to LOAD.
REQ-026 SHALL assert game_over for one cycle in DONE, then return to IDLE with round_idx cleared.
REQ-027 SHALL size the timer to $clog2(ROUND_CYCLES) bits and keep the LFSR non-zero at all times.

Reset
REQ-028 SHALL, on rst, immediately set state=IDLE, led=0, whacked=0, round_done=0, busy=0, game_over=0, round_idx=0, LFSR=LFSR_SEED, timer=0, hit mask=0, and synchronizer=0.
REQ-029 SHALL abandon a game on rst mid-round with no round_done pulse; operation SHALL resume only after a new start.

Configuration
REQ-030 SHALL, with MOLE_SPEEDUP_EN defined, use window = max(ROUND_CYCLES - round_idx*ROUND_STEP, ROUND_MIN) at each LOAD.
REQ-031 SHALL, without MOLE_SPEEDUP_EN, use window = ROUND_CYCLES for every round, leaving ROUND_STEP and ROUND_MIN unused.

Structure
REQ-032 SHALL take from package mole_pkg the constant NUM_MOLES=18, the state enum type, the LFSR tap constants, and the default LFSR_SEED.
REQ-033 SHALL instantiate sub-module mole_lfsr (advance enable, seed load, 18-bit state out).

Verification
REQ-034 SHALL cover: ROUND_CYCLES=8, NUM_ROUNDS=2, no hits -> round_done 10 cycles after LOAD entry (1 LOAD + 8 ACTIVE + REPORT), whacked=0, second round follows, game_over after it.
REQ-035 SHALL cover: pattern 18'h00005, sw[0] then sw[2] rising -> REPORT the cycle after the second synchronized edge, whacked=18'h00005.
REQ-036 SHALL cover: pattern 18'h00005, sw[1] rising -> whacked=0 in REPORT.
REQ-037 SHALL cover: sw[0] edge in the timer==0 cycle -> whacked[0]=1.
REQ-038 SHALL cover: rst mid-ACTIVE -> led=0 and busy=0 immediately, no round_done; a new start replays the LFSR_SEED sequence.
REQ-039 SHALL cover: with MOLE_SPEEDUP_EN, ROUND_CYCLES=20, ROUND_STEP=5, ROUND_MIN=8 -> windows 20, 15, 10, 8, 8.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared constants and types for the whack-a-mole round controller.
// Holds mole count, FSM state encoding, LFSR taps and default seed.
package mole_pkg;

  localparam int NUM_MOLES = 18;

  // x^18 + x^11 + 1, Fibonacci form: feedback from bits 17 and 10
  localparam int LFSR_TAP_HI = 17;
  localparam int LFSR_TAP_LO = 10;

  localparam logic [NUM_MOLES-1:0] LFSR_SEED_DEF = 18'h2A5F3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACTIVE,
    S_REPORT,
    S_DONE
  } state_t;

endpackage

// File: rtl/mole_lfsr.sv
// 18-bit Fibonacci LFSR that supplies the lit-mole pattern.
// Ports: clk, rst (async high), adv (step once), load (reload seed), q (state).
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [NUM_MOLES-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv,
  input  logic                 load,
  output logic [NUM_MOLES-1:0] q
);

  // An all-zero state would lock up, so a zero seed is replaced by 1.
  localparam logic [NUM_MOLES-1:0] SEED_NZ =
    (SEED == '0) ? NUM_MOLES'(1) : SEED;

  logic [NUM_MOLES-1:0] nxt;

  assign nxt = {q[NUM_MOLES-2:0], q[LFSR_TAP_HI] ^ q[LFSR_TAP_LO]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= SEED_NZ;
    end else if (load) begin
      q <= SEED_NZ;
    end else if (adv) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Round controller: lights a random mole pattern, times the window, collects hits.
// Ports: clk, rst (async high), start, sw[17:0] in; led, whacked, round_done,
// busy, game_over, round_idx out. Define MOLE_SPEEDUP_EN to shrink the window
// by ROUND_STEP each round down to ROUND_MIN.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int                   ROUND_CYCLES = 50_000_000,
  parameter int                   NUM_ROUNDS   = 10,
  parameter logic [NUM_MOLES-1:0] LFSR_SEED    = LFSR_SEED_DEF,
  parameter int                   ROUND_STEP   = 2_500_000,
  parameter int                   ROUND_MIN    = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] sw,
  output logic [NUM_MOLES-1:0] led,
  output logic [NUM_MOLES-1:0] whacked,
  output logic                 round_done,
  output logic                 busy,
  output logic                 game_over,
  output logic [3:0]           round_idx
);

  localparam int TW = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

  state_t state, state_nx;

  logic [NUM_MOLES-1:0] pattern;
  logic [NUM_MOLES-1:0] mask, mask_nx, hits;
  logic [NUM_MOLES-1:0] sync1, sync2, sync_prev;
  logic [TW-1:0]        timer, timer_load;
  logic [31:0]          win;
  logic                 expired, full, last_round;

  // The LFSR only steps in LOAD, so its state is the round's pattern.
  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .adv  (state == S_LOAD),
    .load (1'b0),
    .q    (pattern)
  );

`ifdef MOLE_SPEEDUP_EN
  logic [31:0] cut;

  always_comb begin
    cut = 32'(round_idx) * 32'(ROUND_STEP);
    win = 32'(ROUND_MIN);
    if (32'(ROUND_CYCLES) > cut + 32'(ROUND_MIN))
      win = 32'(ROUND_CYCLES) - cut;
  end
`else
  logic [63:0] unused_cfg;

  assign unused_cfg = {32'(ROUND_STEP), 32'(ROUND_MIN)};
  assign win = 32'(ROUND_CYCLES);
`endif

  assign timer_load = TW'(win - 32'd1);

  // A hit is a synchronized rising edge on a lit mole during ACTIVE.
  assign hits = sync2 & ~sync_prev & pattern
              & {NUM_MOLES{state == S_ACTIVE}};
  assign mask_nx    = mask | hits;
  assign full       = (mask_nx == pattern);
  assign expired    = (timer == '0);
  assign last_round = (round_idx == 4'(NUM_ROUNDS - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_LOAD;
      S_LOAD:   state_nx = S_ACTIVE;
      S_ACTIVE: if (expired || full) state_nx = S_REPORT;
      S_REPORT: state_nx = last_round ? S_DONE : S_LOAD;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mask      <= '0;
      timer     <= '0;
      round_idx <= '0;
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
    end else begin
      state     <= state_nx;
      sync1     <= sw;
      sync2     <= sync1;
      sync_prev <= sync2;
      unique case (state)
        S_LOAD: begin
          mask  <= '0;
          timer <= timer_load;
        end
        S_ACTIVE: begin
          mask <= mask_nx;
          if (!expired) timer <= timer - 1'b1;
        end
        S_REPORT: begin
          if (!last_round) round_idx <= round_idx + 4'd1;
        end
        S_DONE: round_idx <= '0;
        default: ;
      endcase
    end
  end

  always_comb begin
    led        = '0;
    whacked    = '0;
    round_done = 1'b0;
    busy       = (state != S_IDLE);
    game_over  = (state == S_DONE);
    if (state == S_ACTIVE || state == S_REPORT) led = pattern;
    if (state == S_REPORT) begin
      whacked    = mask;
      round_done = 1'b1;
    end
  end

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl: timing, hit capture, reset, LFSR replay.
// Define MOLE_SPEEDUP_EN to also exercise the shrinking-window rounds.
module tb_mole_round_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        start1 = 1'b0;
  logic [17:0] sw1 = '0;
  logic [17:0] led1, whacked1;
  logic        rd1, busy1, go1;
  logic [3:0]  idx1;

  logic        start2 = 1'b0;
  logic [17:0] sw2 = '0;
  logic [17:0] led2, whacked2;
  logic        rd2, busy2, go2;
  logic [3:0]  idx2;

  logic        rd3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mole_round_ctrl #(
    .ROUND_CYCLES (8),
    .NUM_ROUNDS   (2)
  ) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .sw         (sw1),
    .led        (led1),
    .whacked    (whacked1),
    .round_done (rd1),
    .busy       (busy1),
    .game_over  (go1),
    .round_idx  (idx1)
  );

  mole_round_ctrl #(
    .ROUND_CYCLES (16),
    .NUM_ROUNDS   (4),
    .LFSR_SEED    (18'h20002)
  ) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .start      (start2),
    .sw         (sw2),
    .led        (led2),
    .whacked    (whacked2),
    .round_done (rd2),
    .busy       (busy2),
    .game_over  (go2),
    .round_idx  (idx2)
  );

`ifdef MOLE_SPEEDUP_EN
  logic        start3 = 1'b0;
  logic [17:0] sw3 = '0;
  logic [17:0] led3, whacked3;
  logic        busy3, go3;
  logic [3:0]  idx3;

  mole_round_ctrl #(
    .ROUND_CYCLES (20),
    .NUM_ROUNDS   (5),
    .ROUND_STEP   (5),
    .ROUND_MIN    (8)
  ) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .sw         (sw3),
    .led        (led3),
    .whacked    (whacked3),
    .round_done (rd3),
    .busy       (busy3),
    .game_over  (go3),
    .round_idx  (idx3)
  );
`else
  assign rd3 = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [17:0] lstep(input logic [17:0] s);
    return {s[16:0], s[17] ^ s[10]};
  endfunction

  // Ticks until the chosen unit reports; -1 if it never does.
  task automatic wait_rd(input int which, output int n);
    logic r;
    n = 0;
    do begin
      tick();
      n++;
      r = (which == 1) ? rd1 : (which == 2) ? rd2 : rd3;
    end while (!r && n < 100);
    if (!r) n = -1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic go2_start();
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    int cnt;
    logic [17:0] p1, p2;

    repeat (2) tick();
    chk("rst_led", led1, 0);
    chk("rst_busy", busy1, 0);
    rst = 1'b0;
    tick();
    chk("rst_rd", rd1, 0);
    chk("rst_go", go1, 0);
    chk("rst_idx", idx1, 0);
    chk("rst_whk", whacked1, 0);

    // two no-hit rounds, window 8
    p1 = lstep(18'h14BE6);
    p2 = lstep(p1);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("load_busy", busy1, 1);
    chk("load_led", led1, 0);
    tick();
    chk("r0_led", led1, 18'h14BE6);
    wait_rd(1, n);
    chk("r0_len", n, 8);
    chk("r0_whk", whacked1, 0);
    chk("r0_idx", idx1, 0);
    tick();
    chk("r1_idx", idx1, 1);
    chk("r1_load_led", led1, 0);
    tick();
    chk("r1_led", led1, p1);
    wait_rd(1, n);
    chk("r1_len", n, 8);
    chk("r1_whk", whacked1, 0);
    tick();
    chk("done_go", go1, 1);
    chk("done_busy", busy1, 1);
    chk("done_rd", rd1, 0);
    tick();
    chk("idle_go", go1, 0);
    chk("idle_busy", busy1, 0);
    chk("idle_idx", idx1, 0);

    // reset in the middle of ACTIVE, then replay from seed
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("g2_led", led1, p2);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_led", led1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_rd", rd1, 0);
    #3;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rd1) cnt++;
    end
    chk("no_rd_after_rst", cnt, 0);
    chk("idle_after_rst", busy1, 0);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("replay_led", led1, 18'h14BE6);

    // pattern 5: hit bit0 then bit2, early finish
    sw2 = '0;
    do_rst();
    go2_start();
    chk("p5_led", led2, 18'h00005);
    sw2 = 18'h00001;
    repeat (3) tick();
    sw2 = 18'h00005;
    repeat (2) tick();
    chk("early_not_yet", rd2, 0);
    tick();
    chk("early_rd", rd2, 1);
    chk("early_whk", whacked2, 18'h00005);
    tick();
    chk("post_whk", whacked2, 0);
    chk("post_idx", idx2, 1);

    // unlit mole hit is ignored
    sw2 = '0;
    do_rst();
    go2_start();
    sw2 = 18'h00002;
    wait_rd(2, n);
    chk("unlit_len", n, 16);
    chk("unlit_whk", whacked2, 0);

    // hit landing in the timer==0 cycle still counts
    sw2 = '0;
    do_rst();
    go2_start();
    repeat (13) tick();
    sw2 = 18'h00001;
    repeat (2) tick();
    chk("last_not_yet", rd2, 0);
    tick();
    chk("last_rd", rd2, 1);
    chk("last_whk", whacked2, 18'h00001);

`ifdef MOLE_SPEEDUP_EN
    begin
      int exp_w[5] = '{20, 15, 10, 8, 8};
      sw2 = '0;
      do_rst();
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      wait_rd(3, n);
      chk("spd_w0", n, exp_w[0] + 1);
      for (int r = 1; r < 5; r++) begin
        wait_rd(3, n);
        chk($sformatf("spd_w%0d", r), n, exp_w[r] + 2);
      end
      tick();
      chk("spd_go", go3, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
